// File: rtl/cic_comb_decim.sv
// cic_comb_decim
// Decimating comb half of a CIC decimator. Every r-th valid integrator sample
// is captured, then pushed through n cascaded differentiators (delay m). All
// arithmetic wraps at w bits so the wrapping integrators upstream cancel out.
module cic_comb_decim #(
    parameter int w = 10,
    parameter int r = 8,
    parameter int m = 1,
    parameter int n = 3
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clr,
    input  logic [w-1:0] din,
    input  logic         din_vld,
    output logic [w-1:0] dout,
    output logic         dout_vld
);

    localparam int cw = (r > 1) ? $clog2(r) : 1;
    localparam logic [cw-1:0] cnt_last = cw'(r - 1);

    logic [cw-1:0] cnt;
    logic          s0;
    logic [w-1:0]  x0;
    // stb[k] is high in the cycle in which comb stage k updates
    logic [n:1]    stb;
    logic [w-1:0]  stage_in  [1:n];
    logic [w-1:0]  stage_out [1:n];

    assign s0 = din_vld && (cnt == cnt_last);

    // decimation phase counter: advances on valid input, wraps at r-1
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (din_vld) begin
            if (cnt == cnt_last) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // decimated sample register, loaded on the last sample of each period
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            x0 <= '0;
        end else if (clr) begin
            x0 <= '0;
        end else if (s0) begin
            x0 <= din;
        end
    end

    // strobe pipeline following the sample through the comb stages
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stb      <= '0;
            dout_vld <= 1'b0;
        end else if (clr) begin
            stb      <= '0;
            dout_vld <= 1'b0;
        end else begin
            stb[1] <= s0;
            for (int k = 2; k <= n; k++) begin
                stb[k] <= stb[k-1];
            end
            dout_vld <= stb[n];
        end
    end

    genvar k;
    generate
        for (k = 1; k <= n; k++) begin : g_stage
            logic [w-1:0] dly [0:m-1];
            logic [w-1:0] y_q;

            if (k == 1) begin : g_first
                assign stage_in[k] = x0;
            end else begin : g_next
                assign stage_in[k] = stage_out[k-1];
            end

            // differentiator: subtract the input seen m strobes ago, wrap at w bits
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    y_q <= '0;
                    for (int j = 0; j < m; j++) begin
                        dly[j] <= '0;
                    end
                end else if (clr) begin
                    y_q <= '0;
                    for (int j = 0; j < m; j++) begin
                        dly[j] <= '0;
                    end
                end else if (stb[k]) begin
                    y_q    <= stage_in[k] - dly[m-1];
                    dly[0] <= stage_in[k];
                    for (int j = 1; j < m; j++) begin
                        dly[j] <= dly[j-1];
                    end
                end
            end

            assign stage_out[k] = y_q;
        end
    endgenerate

    // the last stage register holds its value between strobes
    assign dout = stage_out[n];

endmodule

// File: tb/tb_cic_comb_decim.sv
// Bench for cic_comb_decim: five instances with different (r, m, n) driven by
// directed vectors, a per-cycle reference model and hand-computed anchors.
module tb_cic_comb_decim;

    localparam int NI = 5;

    logic       clk  = 1'b0;
    logic       rstn = 1'b0;
    logic       clr      [NI];
    logic [9:0] din      [NI];
    logic       din_vld  [NI];
    logic [9:0] dout     [NI];
    logic       dout_vld [NI];

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;

    // reference model state
    int acc   [NI];
    int hist  [NI][13];
    int due_r [NI][16];
    int val_r [NI][16];
    int qh    [NI];
    int qt    [NI];
    int last  [NI];

    // log of every dout_vld seen on the DUT
    int log_cyc [NI][256];
    int log_val [NI][256];
    int log_n   [NI];

    function automatic int p_r(input int i);
        case (i)
            0: return 4;
            1: return 1;
            2: return 1;
            3: return 4;
            default: return 8;
        endcase
    endfunction

    function automatic int p_m(input int i);
        return (i == 3) ? 2 : 1;
    endfunction

    function automatic int p_n(input int i);
        case (i)
            0: return 1;
            2: return 1;
            default: return 3;
        endcase
    endfunction

    cic_comb_decim #(.w(10), .r(4), .m(1), .n(1)) u0 (
        .clk(clk), .rstn(rstn), .clr(clr[0]), .din(din[0]), .din_vld(din_vld[0]),
        .dout(dout[0]), .dout_vld(dout_vld[0]));
    cic_comb_decim #(.w(10), .r(1), .m(1), .n(3)) u1 (
        .clk(clk), .rstn(rstn), .clr(clr[1]), .din(din[1]), .din_vld(din_vld[1]),
        .dout(dout[1]), .dout_vld(dout_vld[1]));
    cic_comb_decim #(.w(10), .r(1), .m(1), .n(1)) u2 (
        .clk(clk), .rstn(rstn), .clr(clr[2]), .din(din[2]), .din_vld(din_vld[2]),
        .dout(dout[2]), .dout_vld(dout_vld[2]));
    cic_comb_decim #(.w(10), .r(4), .m(2), .n(3)) u3 (
        .clk(clk), .rstn(rstn), .clr(clr[3]), .din(din[3]), .din_vld(din_vld[3]),
        .dout(dout[3]), .dout_vld(dout_vld[3]));
    cic_comb_decim #(.w(10), .r(8), .m(1), .n(3)) u4 (
        .clk(clk), .rstn(rstn), .clr(clr[4]), .din(din[4]), .din_vld(din_vld[4]),
        .dout(dout[4]), .dout_vld(dout_vld[4]));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int binom(input int nn, input int kk);
        int b;
        b = 1;
        for (int j = 0; j < kk; j++) begin
            b = b * (nn - j) / (j + 1);
        end
        return b;
    endfunction

    task automatic model_clear(input int i);
        acc[i]  = 0;
        qh[i]   = 0;
        qt[i]   = 0;
        last[i] = 0;
        for (int j = 0; j < 13; j++) hist[i][j] = 0;
    endtask

    // n-fold difference with delay m equals the binomial expansion of (1 - z^-m)^n
    task automatic model_capture(input int i);
        int s;
        for (int j = 12; j > 0; j--) hist[i][j] = hist[i][j-1];
        hist[i][0] = int'(din[i]);
        s = 0;
        for (int j = 0; j <= p_n(i); j++) begin
            if (j % 2 == 1) s = s - binom(p_n(i), j) * hist[i][j * p_m(i)];
            else            s = s + binom(p_n(i), j) * hist[i][j * p_m(i)];
        end
        due_r[i][qt[i] % 16] = edge_cnt + p_n(i) + 1;
        val_r[i][qt[i] % 16] = s & 1023;
        qt[i]++;
    endtask

    // model updates on rising edges, outputs are compared on falling edges
    initial begin
        bit exp_v;
        for (int i = 0; i < NI; i++) model_clear(i);
        forever begin
            @(posedge clk or negedge clk or negedge rstn);
            if (!rstn) begin
                for (int i = 0; i < NI; i++) model_clear(i);
            end else if (clk) begin
                for (int i = 0; i < NI; i++) begin
                    if (clr[i]) begin
                        model_clear(i);
                    end else if (din_vld[i]) begin
                        acc[i]++;
                        if (acc[i] == p_r(i)) begin
                            acc[i] = 0;
                            model_capture(i);
                        end
                    end
                end
                edge_cnt++;
            end else begin
                for (int i = 0; i < NI; i++) begin
                    exp_v = (qh[i] != qt[i]) && (due_r[i][qh[i] % 16] == edge_cnt);
                    check($sformatf("u%0d dout_vld cyc %0d", i, edge_cnt), 32'(dout_vld[i]), 32'(exp_v));
                    if (exp_v) begin
                        check($sformatf("u%0d dout cyc %0d", i, edge_cnt), 32'(dout[i]), val_r[i][qh[i] % 16]);
                        last[i] = val_r[i][qh[i] % 16];
                        qh[i]++;
                    end else begin
                        check($sformatf("u%0d dout hold cyc %0d", i, edge_cnt), 32'(dout[i]), last[i]);
                    end
                    if (dout_vld[i] === 1'b1 && log_n[i] < 256) begin
                        log_cyc[i][log_n[i]] = edge_cnt;
                        log_val[i][log_n[i]] = int'(dout[i]);
                        log_n[i]++;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int cnt);
        for (int j = 0; j < cnt; j++) tick();
    endtask

    // u0 ramp result: 3,4,4,4,... with fixed spacing
    task automatic check_ramp(input string tag, input int base, input int t_first,
                              input int spacing);
        int e1 [4];
        e1 = '{3, 4, 4, 4};
        check({tag, " count"}, log_n[0] - base, 6);
        if (t_first >= 0) check({tag, " first latency"}, log_cyc[0][base] - t_first, 2);
        for (int j = 0; j < 4; j++)
            check($sformatf("%s value %0d", tag, j), log_val[0][base + j], e1[j]);
        for (int j = 1; j < 6; j++)
            check($sformatf("%s spacing %0d", tag, j),
                  log_cyc[0][base + j] - log_cyc[0][base + j - 1], spacing);
    endtask

    task automatic ramp_u0(output int t3);
        t3 = -1;
        for (int k = 0; k < 24; k++) begin
            din[0]     = 10'(k);
            din_vld[0] = 1'b1;
            if (k == 3) t3 = edge_cnt;
            tick();
        end
        din_vld[0] = 1'b0;
        ticks(5);
    endtask

    initial begin
        int base0, base1, base2, base3, t3, timp, tclr, tc2, nb, na, fa;
        int e2 [6];
        e2 = '{1, 1021, 3, 1023, 0, 0};
        for (int i = 0; i < NI; i++) begin
            clr[i] = 1'b0; din[i] = '0; din_vld[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #4 rstn = 1'b1;
        tick();
        for (int i = 0; i < NI; i++) begin
            check($sformatf("reset dout u%0d", i), 32'(dout[i]), 0);
            check($sformatf("reset dout_vld u%0d", i), 32'(dout_vld[i]), 0);
        end

        // ramp into r=4 n=1, plus a background stream into the default instance
        base0 = log_n[0];
        t3 = -1;
        for (int k = 0; k < 24; k++) begin
            din[0] = 10'(k);        din_vld[0] = 1'b1;
            din[4] = 10'(k * 37 + 5); din_vld[4] = 1'b1;
            if (k == 3) t3 = edge_cnt;
            tick();
        end
        din_vld[0] = 1'b0; din_vld[4] = 1'b0;
        ticks(5);
        check_ramp("ramp", base0, t3, 4);
        clr[0] = 1'b1; tick(); clr[0] = 1'b0;

        // impulse into r=1 n=3, wrap case into r=1 n=1
        base1 = log_n[1]; base2 = log_n[2];
        timp = edge_cnt;
        for (int k = 0; k < 8; k++) begin
            din[1] = (k == 0) ? 10'd1 : 10'd0;
            din_vld[1] = 1'b1;
            if (k < 2) begin
                din[2] = (k == 0) ? 10'd510 : 10'h202;
                din_vld[2] = 1'b1;
            end else begin
                din_vld[2] = 1'b0;
            end
            tick();
        end
        din_vld[1] = 1'b0;
        ticks(6);
        check("impulse count", log_n[1] - base1, 8);
        for (int j = 0; j < 6; j++) begin
            check($sformatf("impulse value %0d", j), log_val[1][base1 + j], e2[j]);
            check($sformatf("impulse cycle %0d", j), log_cyc[1][base1 + j] - timp, 4 + j);
        end
        check("wrap count", log_n[2] - base2, 2);
        check("wrap first", log_val[2][base2], 510);
        check("wrap result", log_val[2][base2 + 1], 4);

        // valid every other cycle
        base0 = log_n[0];
        for (int k = 0; k < 48; k++) begin
            din[0] = 10'(k / 2);
            din_vld[0] = (k % 2 == 0);
            tick();
        end
        din_vld[0] = 1'b0;
        ticks(4);
        check_ramp("gapped", base0, -1, 8);

        // clr with several strobes in flight at full rate
        base1 = log_n[1];
        for (int k = 0; k < 6; k++) begin
            din[1] = 10'(k * 7 + 5); din_vld[1] = 1'b1; tick();
        end
        clr[1] = 1'b1; din[1] = 10'd100; din_vld[1] = 1'b1;
        tclr = edge_cnt;
        tick();
        clr[1] = 1'b0; din_vld[1] = 1'b0;
        ticks(6);
        na = 0;
        for (int j = base1; j < log_n[1]; j++) if (log_cyc[1][j] > tclr) na++;
        check("clr r1 no stale vld", na, 0);
        check("clr r1 count before", log_n[1] - base1, 3);
        din[1] = 10'd50; din_vld[1] = 1'b1;
        tc2 = edge_cnt;
        tick();
        din_vld[1] = 1'b0;
        ticks(6);
        check("clr r1 restart count", log_n[1] - base1, 4);
        check("clr r1 restart value", log_val[1][log_n[1] - 1], 50);
        check("clr r1 restart cycle", log_cyc[1][log_n[1] - 1] - tc2, 4);

        // clr on r=4 n=3 m=2 while a strobe is still in the pipeline
        base3 = log_n[3];
        for (int k = 0; k < 13; k++) begin
            din[3] = 10'(k * 3 + 1); din_vld[3] = 1'b1; tick();
        end
        clr[3] = 1'b1; din[3] = 10'd999; din_vld[3] = 1'b1;
        tclr = edge_cnt;
        tick();
        clr[3] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            din[3] = 10'(200 + k); din_vld[3] = 1'b1; tick();
        end
        din_vld[3] = 1'b0;
        ticks(10);
        nb = 0; na = 0; fa = -1;
        for (int j = base3; j < log_n[3]; j++) begin
            if (log_cyc[3][j] <= tclr) nb++;
            else begin
                if (na == 0) fa = j;
                na++;
            end
        end
        check("clr r4 outputs before", nb, 2);
        check("clr r4 outputs after", na, 1);
        if (fa >= 0) begin
            check("clr r4 restart cycle", log_cyc[3][fa] - tclr, 8);
            check("clr r4 restart value", log_val[3][fa], 203);
        end else begin
            check("clr r4 restart present", 0, 1);
        end

        // asynchronous reset between edges with work in flight
        for (int k = 0; k < 8; k++) begin
            din[0] = 10'(k); din_vld[0] = 1'b1; tick();
        end
        #3 rstn = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("async reset dout u%0d", i), 32'(dout[i]), 0);
            check($sformatf("async reset dout_vld u%0d", i), 32'(dout_vld[i]), 0);
        end
        repeat (2) @(posedge clk);
        #4 rstn = 1'b1;
        base0 = log_n[0];
        ramp_u0(t3);
        check_ramp("after reset", base0, t3, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
